// File: rtl/mct_arbiter.sv
// Memory-cycle arbiter: at each end-of-cycle strobe, picks whether the next memory cycle
// serves a counter increment, an interrupt entry, or a normal instruction.
module mct_arbiter #(
  parameter int unsigned NCNT          = 8,
  parameter int unsigned NINT          = 4,
  parameter int unsigned IDXW          = 3,
  parameter int unsigned MAX_CNT_BURST = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            tp_end,
  input  logic [NCNT-1:0] cnt_req,
  input  logic [NINT-1:0] int_req,
  input  logic            ien,
  input  logic            resume,
  output logic [1:0]      cyc_type,
  output logic [IDXW-1:0] cyc_idx,
  output logic            cyc_start,
  output logic [NCNT-1:0] cnt_ack,
  output logic [NINT-1:0] int_ack,
  output logic            in_isr,
  output logic            cnt_overrun
);

  localparam int unsigned BW = $clog2(MAX_CNT_BURST + 1);

  typedef enum logic [1:0] {StInst = 2'b00, StCnt = 2'b01, StInt = 2'b10} state_e;

  state_e          state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [NCNT-1:0] cnt_pend_q, cnt_pend_d;
  logic [NINT-1:0] int_pend_q, int_pend_d;
  logic [BW-1:0]   burst_q, burst_d;
  logic            start_q, start_d;
  logic [NCNT-1:0] cnt_ack_q, cnt_ack_d;
  logic [NINT-1:0] int_ack_q, int_ack_d;
  logic            isr_q, isr_d;
  logic            ovr_q, ovr_d;

  logic [NCNT-1:0] cnt_eff, cnt_gnt;
  logic [NINT-1:0] int_eff, int_gnt;
  logic [IDXW-1:0] cnt_sel, int_sel;
  logic            cnt_hit, int_hit, grant_cnt, grant_int, isr_eff;

  // Lowest-index-first priority encoders over pending OR same-clock requests.
  always_comb begin
    cnt_eff = cnt_pend_q | cnt_req;
    int_eff = int_pend_q | int_req;
    cnt_hit = 1'b0;
    cnt_sel = '0;
    for (int i = NCNT - 1; i >= 0; i--) begin
      if (cnt_eff[i]) begin
        cnt_hit = 1'b1;
        cnt_sel = IDXW'(i);
      end
    end
    int_hit = 1'b0;
    int_sel = '0;
    for (int j = NINT - 1; j >= 0; j--) begin
      if (int_eff[j]) begin
        int_hit = 1'b1;
        int_sel = IDXW'(j);
      end
    end
  end

  // A resume on the decision clock already frees the way for a new interrupt.
  assign isr_eff   = isr_q & ~resume;
  assign grant_cnt = tp_end & cnt_hit & (burst_q < BW'(MAX_CNT_BURST));
  assign grant_int = tp_end & ~grant_cnt & int_hit & ien & ~isr_eff;
  assign cnt_gnt   = grant_cnt ? (NCNT'(1) << cnt_sel) : '0;
  assign int_gnt   = grant_int ? (NINT'(1) << int_sel) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StInst;
      idx_q      <= '0;
      cnt_pend_q <= '0;
      int_pend_q <= '0;
      burst_q    <= '0;
      start_q    <= 1'b0;
      cnt_ack_q  <= '0;
      int_ack_q  <= '0;
      isr_q      <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_pend_q <= cnt_pend_d;
      int_pend_q <= int_pend_d;
      burst_q    <= burst_d;
      start_q    <= start_d;
      cnt_ack_q  <= cnt_ack_d;
      int_ack_q  <= int_ack_d;
      isr_q      <= isr_d;
      ovr_q      <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    burst_d = burst_q;
    if (tp_end) begin
      if (grant_cnt) begin
        state_d = StCnt;
        idx_d   = cnt_sel;
        // grant_cnt already implies burst_q < MAX_CNT_BURST, so this saturates.
        burst_d = burst_q + BW'(1);
      end else if (grant_int) begin
        state_d = StInt;
        idx_d   = int_sel;
        burst_d = '0;
      end else begin
        state_d = StInst;
        idx_d   = '0;
        burst_d = '0;
      end
    end
    // A request landing on its own grant clock re-arms the pending bit.
    cnt_pend_d = (cnt_pend_q & ~cnt_gnt) | cnt_req;
    int_pend_d = (int_pend_q & ~int_gnt) | int_req;
    ovr_d      = ovr_q | (|(cnt_req & cnt_pend_q & ~cnt_gnt));
    isr_d      = grant_int ? 1'b1 : (resume ? 1'b0 : isr_q);
    start_d    = tp_end;
    cnt_ack_d  = cnt_gnt;
    int_ack_d  = int_gnt;
  end

  always_comb begin
    cyc_type    = state_q;
    cyc_idx     = idx_q;
    cyc_start   = start_q;
    cnt_ack     = cnt_ack_q;
    int_ack     = int_ack_q;
    in_isr      = isr_q;
    cnt_overrun = ovr_q;
  end

endmodule

// File: tb/tb_mct_arbiter.sv
// Directed table-driven bench for mct_arbiter: one row per 7-clock memory cycle.
module tb_mct_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tp_end;
  logic [7:0] cnt_req;
  logic [3:0] int_req;
  logic       ien;
  logic       resume;
  logic [1:0] cyc_type;
  logic [2:0] cyc_idx;
  logic       cyc_start;
  logic [7:0] cnt_ack;
  logic [3:0] int_ack;
  logic       in_isr;
  logic       cnt_overrun;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mct_arbiter #(
    .NCNT(8), .NINT(4), .IDXW(3), .MAX_CNT_BURST(4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tp_end     (tp_end),
    .cnt_req    (cnt_req),
    .int_req    (int_req),
    .ien        (ien),
    .resume     (resume),
    .cyc_type   (cyc_type),
    .cyc_idx    (cyc_idx),
    .cyc_start  (cyc_start),
    .cnt_ack    (cnt_ack),
    .int_ack    (int_ack),
    .in_isr     (in_isr),
    .cnt_overrun(cnt_overrun)
  );

  // c at clock 2, c2 at clock 4, i/r at clock 2, rt = resume on the tp_end clock.
  typedef struct packed {
    logic [7:0] c;
    logic [7:0] c2;
    logic [3:0] i;
    logic       r;
    logic       rt;
    logic       e;
    logic [1:0] t;
    logic [2:0] x;
    logic [7:0] ca;
    logic [3:0] ia;
    logic       isr;
    logic       ovr;
  } vec_t;

  localparam int NV = 27;
  vec_t tab [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    tp_end  = 1'b0;
    cnt_req = '0;
    int_req = '0;
    resume  = 1'b0;
  endtask

  task automatic run_row(input int n, input vec_t v);
    for (int k = 0; k < 7; k++) begin
      if (k == 1) begin
        chk($sformatf("row%0d start_low", n), 32'(cyc_start), 32'd0);
        chk($sformatf("row%0d acks_low", n), 32'({cnt_ack, int_ack}), 32'd0);
      end
      if (k == 6) chk($sformatf("row%0d start_before_tp", n), 32'(cyc_start), 32'd0);
      ien     = v.e;
      tp_end  = (k == 6);
      cnt_req = (k == 2) ? v.c : ((k == 4) ? v.c2 : 8'h00);
      int_req = (k == 2) ? v.i : 4'h0;
      resume  = ((k == 2) && v.r) || ((k == 6) && v.rt);
      @(negedge clk);
    end
    idle_inputs();
    chk($sformatf("row%0d cyc_start", n), 32'(cyc_start), 32'd1);
    chk($sformatf("row%0d cyc_type", n), 32'(cyc_type), 32'(v.t));
    chk($sformatf("row%0d cyc_idx", n), 32'(cyc_idx), 32'(v.x));
    chk($sformatf("row%0d cnt_ack", n), 32'(cnt_ack), 32'(v.ca));
    chk($sformatf("row%0d int_ack", n), 32'(int_ack), 32'(v.ia));
    chk($sformatf("row%0d in_isr", n), 32'(in_isr), 32'(v.isr));
    chk($sformatf("row%0d cnt_overrun", n), 32'(cnt_overrun), 32'(v.ovr));
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, " cyc_type"}, 32'(cyc_type), 32'd0);
    chk({name, " cyc_idx"}, 32'(cyc_idx), 32'd0);
    chk({name, " cyc_start"}, 32'(cyc_start), 32'd0);
    chk({name, " acks"}, 32'({cnt_ack, int_ack}), 32'd0);
    chk({name, " in_isr"}, 32'(in_isr), 32'd0);
    chk({name, " cnt_overrun"}, 32'(cnt_overrun), 32'd0);
  endtask

  initial begin
    //              c      c2     i     r  rt e  t      x     ca     ia    isr ovr
    tab[0]  = '{8'h00, 8'h00, 4'h0, 0, 0, 0, 2'b00, 3'd0, 8'h00, 4'h0, 0, 0};
    tab[1]  = '{8'h00, 8'h00, 4'h0, 0, 0, 0, 2'b00, 3'd0, 8'h00, 4'h0, 0, 0};
    tab[2]  = '{8'h24, 8'h00, 4'h0, 0, 0, 0, 2'b01, 3'd2, 8'h04, 4'h0, 0, 0};
    tab[3]  = '{8'h00, 8'h00, 4'h0, 0, 0, 0, 2'b01, 3'd5, 8'h20, 4'h0, 0, 0};
    tab[4]  = '{8'h00, 8'h00, 4'h0, 0, 0, 0, 2'b00, 3'd0, 8'h00, 4'h0, 0, 0};
    tab[5]  = '{8'h01, 8'h00, 4'h2, 0, 0, 1, 2'b01, 3'd0, 8'h01, 4'h0, 0, 0};
    tab[6]  = '{8'h00, 8'h00, 4'h0, 0, 0, 1, 2'b10, 3'd1, 8'h00, 4'h2, 1, 0};
    tab[7]  = '{8'h00, 8'h00, 4'h1, 0, 0, 1, 2'b00, 3'd0, 8'h00, 4'h0, 1, 0};
    tab[8]  = '{8'h00, 8'h00, 4'h0, 0, 0, 1, 2'b00, 3'd0, 8'h00, 4'h0, 1, 0};
    tab[9]  = '{8'h00, 8'h00, 4'h0, 1, 0, 1, 2'b10, 3'd0, 8'h00, 4'h1, 1, 0};
    tab[10] = '{8'h00, 8'h00, 4'h0, 1, 0, 1, 2'b00, 3'd0, 8'h00, 4'h0, 0, 0};
    // Burst limit: four counter cycles, one forced INST, then the rest.
    tab[11] = '{8'hFF, 8'h00, 4'h0, 0, 0, 0, 2'b01, 3'd0, 8'h01, 4'h0, 0, 0};
    tab[12] = '{8'h00, 8'h00, 4'h0, 0, 0, 0, 2'b01, 3'd1, 8'h02, 4'h0, 0, 0};
    tab[13] = '{8'h00, 8'h00, 4'h0, 0, 0, 0, 2'b01, 3'd2, 8'h04, 4'h0, 0, 0};
    tab[14] = '{8'h00, 8'h00, 4'h0, 0, 0, 0, 2'b01, 3'd3, 8'h08, 4'h0, 0, 0};
    tab[15] = '{8'h00, 8'h00, 4'h0, 0, 0, 0, 2'b00, 3'd0, 8'h00, 4'h0, 0, 0};
    tab[16] = '{8'h00, 8'h00, 4'h0, 0, 0, 0, 2'b01, 3'd4, 8'h10, 4'h0, 0, 0};
    tab[17] = '{8'h00, 8'h00, 4'h0, 0, 0, 0, 2'b01, 3'd5, 8'h20, 4'h0, 0, 0};
    tab[18] = '{8'h00, 8'h00, 4'h0, 0, 0, 0, 2'b01, 3'd6, 8'h40, 4'h0, 0, 0};
    tab[19] = '{8'h00, 8'h00, 4'h0, 0, 0, 0, 2'b01, 3'd7, 8'h80, 4'h0, 0, 0};
    tab[20] = '{8'h00, 8'h00, 4'h0, 0, 0, 0, 2'b00, 3'd0, 8'h00, 4'h0, 0, 0};
    // Double request on counter 3 before the decision.
    tab[21] = '{8'h08, 8'h08, 4'h0, 0, 0, 0, 2'b01, 3'd3, 8'h08, 4'h0, 0, 1};
    tab[22] = '{8'h00, 8'h00, 4'h0, 0, 0, 0, 2'b00, 3'd0, 8'h00, 4'h0, 0, 1};
    // ien low keeps interrupt 2 pending until enabled.
    tab[23] = '{8'h00, 8'h00, 4'h4, 0, 0, 0, 2'b00, 3'd0, 8'h00, 4'h0, 0, 1};
    tab[24] = '{8'h00, 8'h00, 4'h0, 0, 0, 1, 2'b10, 3'd2, 8'h00, 4'h4, 1, 1};
    // Resume on the tp_end clock lets pending interrupt 0 win that same decision.
    tab[25] = '{8'h00, 8'h00, 4'h1, 0, 0, 1, 2'b00, 3'd0, 8'h00, 4'h0, 1, 1};
    tab[26] = '{8'h00, 8'h00, 4'h0, 0, 1, 1, 2'b10, 3'd0, 8'h00, 4'h1, 1, 1};

    rst_n = 1'b0;
    ien   = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;

    for (int n = 0; n < NV; n++) run_row(n, tab[n]);

    // Asynchronous reset with a pending counter and an interrupt in service.
    cnt_req = 8'h04;
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    run_row(99, '{8'h00, 8'h00, 4'h0, 0, 0, 1, 2'b00, 3'd0, 8'h00, 4'h0, 0, 0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
